// File: rtl/clkdiv_ramp_ctrl.sv
// Divisor ramp sequencer for a fractional clock divider: slews {int,frac} from a start
// value toward a commanded target by a fixed step on each divider output tick.
module clkdiv_ramp_ctrl #(
  parameter int W_DIV_INT  = 16,
  parameter int W_DIV_FRAC = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [W_DIV_INT+W_DIV_FRAC-1:0]  cfg_start_div,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_stop,
  input  logic [W_DIV_INT+W_DIV_FRAC-1:0]  cmd_target,
  input  logic [W_DIV_INT+W_DIV_FRAC-1:0]  cmd_step,
  input  logic                             abort,
  input  logic                             tick_in,
  output logic                             div_en,
  output logic [W_DIV_INT-1:0]             div_int,
  output logic [W_DIV_FRAC-1:0]            div_frac,
  output logic                             busy,
  output logic                             at_target
);

  localparam int W = W_DIV_INT + W_DIV_FRAC;
  localparam logic [W-1:0] DIV_ONE = W'(1) << W_DIV_FRAC;

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_RUN, ST_STOP} state_t;

  // The divider cannot run with an integer part of zero; such divisors become 1.0.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
    if (d[W-1:W_DIV_FRAC] == {W_DIV_INT{1'b0}}) begin
      return DIV_ONE;
    end else begin
      return d;
    end
  endfunction

  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt,
                                               input logic [W-1:0] stp);
    logic [W-1:0] diff;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    if (stp == {W{1'b0}} || diff <= stp) begin
      return tgt;
    end else if (tgt > cur) begin
      return cur + stp;
    end else begin
      return cur - stp;
    end
  endfunction

  state_t       state;
  state_t       next_state;
  logic [W-1:0] div;
  logic [W-1:0] target;
  logic [W-1:0] step;
  logic         ready_state;
  logic         accept;
  logic         tick_act;
  logic [W-1:0] start_c;
  logic [W-1:0] cmd_tgt_c;
  logic [W-1:0] tick_div;

  // Abort must block acceptance in the very cycle it is raised.
  assign cmd_ready = ready_state & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign start_c   = clamp_div(cfg_start_div);
  assign cmd_tgt_c = clamp_div(cmd_target);
  assign tick_act  = tick_in & ((state == ST_RAMP) | (state == ST_STOP));
  assign tick_div  = tick_act ? step_toward(div, target, step) : div;
  assign div_int   = div[W-1:W_DIV_FRAC];
  assign div_frac  = div[W_DIV_FRAC-1:0];

  // Next-state selection; run commands are judged against the post-tick divisor.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !cmd_stop) begin
            next_state = (start_c == cmd_tgt_c) ? ST_RUN : ST_RAMP;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_RAMP, ST_RUN: begin
          if (accept && !cmd_stop) begin
            next_state = (tick_div == cmd_tgt_c) ? ST_RUN : ST_RAMP;
          end else if (accept) begin
            next_state = ST_STOP;
          end else if (tick_act && tick_div == target) begin
            next_state = ST_RUN;
          end else begin
            next_state = state;
          end
        end
        ST_STOP: begin
          if (tick_act && tick_div == target) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_STOP;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Controller state, latched command and registered divider-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      div         <= DIV_ONE;
      target      <= DIV_ONE;
      step        <= {W{1'b0}};
      div_en      <= 1'b0;
      busy        <= 1'b0;
      at_target   <= 1'b0;
      ready_state <= 1'b1;
    end else begin
      state       <= next_state;
      busy        <= (next_state != ST_IDLE);
      at_target   <= (next_state == ST_RUN);
      ready_state <= (next_state != ST_STOP);
      if (abort) begin
        div_en <= 1'b0;
      end else if (state == ST_IDLE && accept && !cmd_stop) begin
        div    <= start_c;
        target <= cmd_tgt_c;
        step   <= cmd_step;
        div_en <= 1'b1;
      end else if (accept && state != ST_IDLE) begin
        // The tick (if any) still uses the old target/step; new values apply next tick.
        div    <= tick_div;
        target <= cmd_stop ? start_c : cmd_tgt_c;
        step   <= cmd_step;
      end else begin
        div <= tick_div;
        if (next_state == ST_IDLE) begin
          div_en <= 1'b0;
        end else begin
          div_en <= div_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ramp_ctrl.sv
// Scoreboard bench for clkdiv_ramp_ctrl: directed ramp scenarios followed by random
// commands, ticks, aborts and resets, checked against an arithmetic reference model.
module tb_clkdiv_ramp_ctrl;
  localparam int WI = 16;
  localparam int WF = 8;
  localparam int W  = WI + WF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  cfg_start_div = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_stop = 1'b0;
  logic [W-1:0]  cmd_target = '0;
  logic [W-1:0]  cmd_step = '0;
  logic          abort = 1'b0;
  logic          tick_in = 1'b0;
  logic          div_en;
  logic [WI-1:0] div_int;
  logic [WF-1:0] div_frac;
  logic          busy;
  logic          at_target;

  clkdiv_ramp_ctrl #(.W_DIV_INT(WI), .W_DIV_FRAC(WF)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_div(cfg_start_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stop(cmd_stop),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .abort(abort), .tick_in(tick_in),
    .div_en(div_en), .div_int(div_int), .div_frac(div_frac),
    .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         en;
    logic [W-1:0] div;
    logic         busy;
    logic         at;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode names and plain integer arithmetic on the divisor value.
  localparam int M_IDLE = 0, M_RAMP = 1, M_RUN = 2, M_STOP = 3;
  int     m_mode = M_IDLE;
  bit     m_en = 1'b0;
  longint m_div = 256, m_tgt = 256, m_step = 0;

  function automatic longint clampv(input longint d);
    return (d < 256) ? 64'sd256 : d;
  endfunction

  function automatic longint toward(input longint c, input longint t, input longint s);
    longint diff;
    diff = (t > c) ? t - c : c - t;
    if (s == 0 || diff <= s) return t;
    return (t > c) ? c + s : c - s;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update();
    bit acc;
    if (!rst_n) begin
      m_mode = M_IDLE; m_en = 1'b0; m_div = 256;
    end else if (abort) begin
      m_mode = M_IDLE; m_en = 1'b0;
    end else begin
      acc = cmd_valid && (m_mode != M_STOP);
      case (m_mode)
        M_IDLE: begin
          if (acc && !cmd_stop) begin
            m_div = clampv(longint'(cfg_start_div));
            m_tgt = clampv(longint'(cmd_target));
            m_step = longint'(cmd_step);
            m_en = 1'b1;
            m_mode = (m_div == m_tgt) ? M_RUN : M_RAMP;
          end
        end
        M_RAMP, M_RUN: begin
          if (m_mode == M_RAMP && tick_in) begin
            m_div = toward(m_div, m_tgt, m_step);
            if (m_div == m_tgt) m_mode = M_RUN;
          end
          if (acc && !cmd_stop) begin
            m_tgt = clampv(longint'(cmd_target));
            m_step = longint'(cmd_step);
            m_mode = (m_div == m_tgt) ? M_RUN : M_RAMP;
          end else if (acc) begin
            m_tgt = clampv(longint'(cfg_start_div));
            m_step = longint'(cmd_step);
            m_mode = M_STOP;
          end
        end
        default: begin
          if (tick_in) begin
            m_div = toward(m_div, m_tgt, m_step);
            if (m_div == m_tgt) begin
              m_mode = M_IDLE; m_en = 1'b0;
            end
          end
        end
      endcase
    end
    exp_q.push_back('{en: m_en, div: W'(m_div), busy: (m_mode != M_IDLE),
                      at: (m_mode == M_RUN), rdy: (m_mode != M_STOP)});
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, advance.
  task automatic cyc(input logic v, input logic s, input logic [W-1:0] t,
                     input logic [W-1:0] st, input logic ab, input logic tk);
    cmd_valid = v; cmd_stop = s; cmd_target = t; cmd_step = st; abort = ab; tick_in = tk;
    model_update();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_n(input int n, input logic tk);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, tk);
  endtask

  // Monitor: one expected snapshot per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_en", W'(div_en), W'(e.en));
        chk("divisor", {div_int, div_frac}, e.div);
        chk("busy", W'(busy), W'(e.busy));
        chk("at_target", W'(at_target), W'(e.at));
        chk("cmd_ready", W'(cmd_ready), W'(e.rdy & ~abort));
      end
    end
  end

  task automatic async_reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_rst_div_en", W'(div_en), W'(1'b0));
    chk("async_rst_divisor", {div_int, div_frac}, 24'h000100);
    chk("async_rst_busy", W'(busy), W'(1'b0));
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] t, st;
    int sel;
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cfg_start_div = 24'h000A00;
    idle_n(2, 1'b1);

    // Exact-multiple ramp down, then stop back to start.
    cyc(1'b1, 1'b0, 24'h000400, 24'h000200, 1'b0, 1'b0);
    idle_n(2, 1'b0);
    idle_n(1, 1'b1); idle_n(1, 1'b0); idle_n(1, 1'b1); idle_n(1, 1'b1);
    idle_n(2, 1'b1);
    cyc(1'b1, 1'b1, '0, 24'h000300, 1'b0, 1'b0);
    idle_n(1, 1'b0); idle_n(1, 1'b1); idle_n(1, 1'b0); idle_n(1, 1'b1);
    idle_n(2, 1'b0);

    // Non-multiple ramp, then a zero-step jump.
    cyc(1'b1, 1'b0, 24'h000380, 24'h000300, 1'b0, 1'b0);
    idle_n(4, 1'b1);
    cyc(1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    idle_n(1, 1'b1);
    cyc(1'b1, 1'b0, 24'h000380, '0, 1'b0, 1'b0);
    idle_n(1, 1'b0); idle_n(1, 1'b1);

    // Retarget in the same cycle as a tick, reversing direction onto a clamped target.
    cyc(1'b1, 1'b0, 24'h001000, 24'h000200, 1'b0, 1'b0);
    idle_n(1, 1'b1);
    cyc(1'b1, 1'b0, 24'h000080, 24'h000100, 1'b0, 1'b1);
    idle_n(1, 1'b0);
    idle_n(8, 1'b1);

    // Abort mid-ramp, then reset mid-ramp.
    cyc(1'b1, 1'b0, 24'h002000, 24'h000100, 1'b0, 1'b0);
    idle_n(2, 1'b1);
    cyc(1'b1, 1'b0, 24'h000500, 24'h000100, 1'b1, 1'b1);
    idle_n(2, 1'b1);
    cyc(1'b1, 1'b0, 24'h002000, 24'h000100, 1'b0, 1'b0);
    idle_n(2, 1'b1);
    async_reset_pulse();
    idle_n(1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) cfg_start_div = W'($urandom_range(0, 32'h3000));
      if ($urandom_range(0, 999) == 0) begin
        async_reset_pulse();
      end else begin
        t = W'($urandom_range(0, 32'h3000));
        sel = $urandom_range(0, 3);
        case (sel)
          0: st = '0;
          1: st = W'($urandom_range(1, 255));
          2: st = W'($urandom_range(256, 4096));
          default: st = W'($urandom);
        endcase
        cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), t, st,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0));
      end
    end
    idle_n(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
